// File: rtl/seg7_decoder_monitor.sv
// Receive-side monitor for a 7-segment display bus. It recovers the hex digit,
// debounces the pattern, classifies it, checks it against the claimed LED nibble
// and counts accepted digit changes.
module seg7_decoder_monitor #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned NBITS_CNT     = 8
) (
    input  logic                 clk_2,
    input  logic                 reset,
    input  logic [7:0]           seg_in,
    input  logic [3:0]           led_nib,
    output logic [3:0]           value,
    output logic                 value_valid,
    output logic                 dp,
    output logic                 blank,
    output logic                 invalid,
    output logic                 mismatch,
    output logic                 mismatch_err,
    output logic [NBITS_CNT-1:0] count
);

    localparam int unsigned STAB_W = 8;

    typedef enum logic [1:0] {
        ST_BLANK,
        ST_SETTLE,
        ST_LOCKED,
        ST_ILLEGAL
    } state_t;

    state_t                state, state_d;
    logic [7:0]            sampled;
    logic [STAB_W-1:0]     stab_cnt, stab_cnt_d, stab_inc;
    logic                  have_legal, have_legal_d;
    logic [3:0]            value_d;
    logic                  value_valid_d, dp_d, blank_d, invalid_d;
    logic                  mismatch_d, mismatch_err_d;
    logic [NBITS_CNT-1:0]  count_d;
    logic [3:0]            dec_val;
    logic                  dec_legal;
    logic                  dec_blank;
    logic                  changed;
    logic                  accept;

    // Segment pattern (bits 6:0) to hex digit lookup.
    always_comb begin
        dec_val   = 4'h0;
        dec_legal = 1'b1;
        unique case (seg_in[6:0])
            7'h3F:   dec_val = 4'h0;
            7'h06:   dec_val = 4'h1;
            7'h5B:   dec_val = 4'h2;
            7'h4F:   dec_val = 4'h3;
            7'h66:   dec_val = 4'h4;
            7'h6D:   dec_val = 4'h5;
            7'h7D:   dec_val = 4'h6;
            7'h07:   dec_val = 4'h7;
            7'h7F:   dec_val = 4'h8;
            7'h6F:   dec_val = 4'h9;
            7'h77:   dec_val = 4'hA;
            7'h7C:   dec_val = 4'hB;
            7'h39:   dec_val = 4'hC;
            7'h5E:   dec_val = 4'hD;
            7'h79:   dec_val = 4'hE;
            7'h71:   dec_val = 4'hF;
            default: dec_legal = 1'b0;
        endcase
        dec_blank = (seg_in[6:0] == 7'h00);
    end

    // Debounce FSM next-state and next values of the registered outputs.
    always_comb begin
        state_d        = state;
        stab_cnt_d     = stab_cnt;
        have_legal_d   = have_legal;
        value_d        = value;
        value_valid_d  = value_valid;
        dp_d           = dp;
        blank_d        = blank;
        invalid_d      = invalid;
        mismatch_d     = mismatch;
        mismatch_err_d = mismatch_err;
        count_d        = count;
        accept         = 1'b0;
        changed        = (seg_in != sampled);
        stab_inc       = STAB_W'(stab_cnt + STAB_W'(1));

        if (changed) begin
            state_d    = ST_SETTLE;
            stab_cnt_d = STAB_W'(1);
            accept     = (STABLE_CYCLES == 1);
        end else if (state == ST_SETTLE) begin
            stab_cnt_d = stab_inc;
            accept     = (stab_inc == STAB_W'(STABLE_CYCLES));
        end

        if (accept) begin
            dp_d = seg_in[7];
            if (dec_legal) begin
                state_d        = ST_LOCKED;
                value_d        = dec_val;
                value_valid_d  = 1'b1;
                blank_d        = 1'b0;
                invalid_d      = 1'b0;
                mismatch_d     = (dec_val != led_nib);
                mismatch_err_d = mismatch_err | (dec_val != led_nib);
                have_legal_d   = 1'b1;
                if ((!have_legal || (dec_val != value)) && (count != {NBITS_CNT{1'b1}})) begin
                    count_d = NBITS_CNT'(count + NBITS_CNT'(1));
                end
            end else begin
                state_d       = dec_blank ? ST_BLANK : ST_ILLEGAL;
                value_valid_d = 1'b0;
                blank_d       = dec_blank;
                invalid_d     = !dec_blank;
                mismatch_d    = 1'b0;
                have_legal_d  = 1'b0;
            end
        end
    end

    // State, sampled pattern and output registers; reset wins over any accept.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            state        <= ST_BLANK;
            sampled      <= 8'h00;
            stab_cnt     <= '0;
            have_legal   <= 1'b0;
            value        <= 4'h0;
            value_valid  <= 1'b0;
            dp           <= 1'b0;
            blank        <= 1'b1;
            invalid      <= 1'b0;
            mismatch     <= 1'b0;
            mismatch_err <= 1'b0;
            count        <= '0;
        end else begin
            state        <= state_d;
            sampled      <= seg_in;
            stab_cnt     <= stab_cnt_d;
            have_legal   <= have_legal_d;
            value        <= value_d;
            value_valid  <= value_valid_d;
            dp           <= dp_d;
            blank        <= blank_d;
            invalid      <= invalid_d;
            mismatch     <= mismatch_d;
            mismatch_err <= mismatch_err_d;
            count        <= count_d;
        end
    end

endmodule

// File: tb/tb_seg7_decoder_monitor.sv
// Directed bench for seg7_decoder_monitor: a vector table for the default
// configuration plus short sequences for a 2-bit counter and a 1-cycle window.
module tb_seg7_decoder_monitor;

    logic       clk_2 = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] seg_in = 8'h00;
    logic [3:0] led_nib = 4'h0;

    // Default instance (STABLE_CYCLES=4, NBITS_CNT=8)
    logic [3:0] value_a;
    logic       vv_a, dp_a, blank_a, inv_a, mm_a, mme_a;
    logic [7:0] count_a;
    // Saturation instance (NBITS_CNT=2)
    logic [3:0] value_b;
    logic       vv_b, dp_b, blank_b, inv_b, mm_b, mme_b;
    logic [1:0] count_b;
    // Single-cycle window instance (STABLE_CYCLES=1)
    logic [3:0] value_c;
    logic       vv_c, dp_c, blank_c, inv_c, mm_c, mme_c;
    logic [7:0] count_c;

    int checks   = 0;
    int failures = 0;

    always #5 clk_2 = ~clk_2;

    seg7_decoder_monitor #(.STABLE_CYCLES(4), .NBITS_CNT(8)) dut_a (
        .clk_2(clk_2), .reset(reset), .seg_in(seg_in), .led_nib(led_nib),
        .value(value_a), .value_valid(vv_a), .dp(dp_a), .blank(blank_a),
        .invalid(inv_a), .mismatch(mm_a), .mismatch_err(mme_a), .count(count_a)
    );

    seg7_decoder_monitor #(.STABLE_CYCLES(4), .NBITS_CNT(2)) dut_b (
        .clk_2(clk_2), .reset(reset), .seg_in(seg_in), .led_nib(led_nib),
        .value(value_b), .value_valid(vv_b), .dp(dp_b), .blank(blank_b),
        .invalid(inv_b), .mismatch(mm_b), .mismatch_err(mme_b), .count(count_b)
    );

    seg7_decoder_monitor #(.STABLE_CYCLES(1), .NBITS_CNT(8)) dut_c (
        .clk_2(clk_2), .reset(reset), .seg_in(seg_in), .led_nib(led_nib),
        .value(value_c), .value_valid(vv_c), .dp(dp_c), .blank(blank_c),
        .invalid(inv_c), .mismatch(mm_c), .mismatch_err(mme_c), .count(count_c)
    );

    // Packed output image: value, valid, dp, blank, invalid, mismatch, mismatch_err, count
    typedef logic [17:0] outs_t;

    typedef struct {
        string      name;
        logic       rst;
        logic [7:0] seg;
        logic [3:0] nib;
        int         edges;
        outs_t      exp;
    } vec_t;

    vec_t vecs[$];

    function automatic outs_t mk(input logic [3:0] v, input logic vv, input logic d,
                                 input logic bl, input logic iv, input logic m,
                                 input logic me, input logic [7:0] c);
        return {v, vv, d, bl, iv, m, me, c};
    endfunction

    function automatic void add(input string n, input logic r, input logic [7:0] s,
                                input logic [3:0] nb, input int e, input outs_t x);
        vec_t t;
        t.name = n; t.rst = r; t.seg = s; t.nib = nb; t.edges = e; t.exp = x;
        vecs.push_back(t);
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_2);
            #1;
        end
    endtask

    task automatic check(input string n, input outs_t act, input outs_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %05h expected %05h", n, act, exp);
        end
    endtask

    task automatic check_cnt(input string n, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    outs_t rst_vals;
    outs_t act;
    logic [7:0] pat_b[5];
    logic [1:0] exp_b[5];

    initial begin
        rst_vals = mk(4'h0, 0, 0, 1, 0, 0, 0, 8'd0);

        add("reset",            1, 8'h00, 4'h0, 1, rst_vals);
        add("settle5_hold",     0, 8'h6D, 4'h5, 3, rst_vals);
        add("accept5",          0, 8'h6D, 4'h5, 1, mk(4'h5, 1, 0, 0, 0, 0, 0, 8'd1));
        add("locked5_stable",   0, 8'h6D, 4'h5, 3, mk(4'h5, 1, 0, 0, 0, 0, 0, 8'd1));
        add("short6_ignored",   0, 8'h7D, 4'h9, 2, mk(4'h5, 1, 0, 0, 0, 0, 0, 8'd1));
        add("settle9_hold",     0, 8'h6F, 4'h9, 3, mk(4'h5, 1, 0, 0, 0, 0, 0, 8'd1));
        add("accept9",          0, 8'h6F, 4'h9, 1, mk(4'h9, 1, 0, 0, 0, 0, 0, 8'd2));
        add("accept_c_mismatch",0, 8'h39, 4'h9, 4, mk(4'hC, 1, 0, 0, 0, 1, 1, 8'd3));
        add("accept9_sticky",   0, 8'h6F, 4'h9, 4, mk(4'h9, 1, 0, 0, 0, 0, 1, 8'd4));
        add("blank_holds9",     0, 8'h00, 4'h9, 4, mk(4'h9, 0, 0, 1, 0, 0, 1, 8'd4));
        add("invalid49",        0, 8'h49, 4'h9, 4, mk(4'h9, 0, 0, 0, 1, 0, 1, 8'd4));
        add("reaccept9_counts", 0, 8'h6F, 4'h9, 4, mk(4'h9, 1, 0, 0, 0, 0, 1, 8'd5));
        add("dp_only_change",   0, 8'hEF, 4'h9, 4, mk(4'h9, 1, 1, 0, 0, 0, 1, 8'd5));
        add("blank_with_dp",    0, 8'h80, 4'h9, 4, mk(4'h9, 0, 1, 1, 0, 0, 1, 8'd5));
        add("settle6_pre_rst",  0, 8'h7D, 4'h6, 2, mk(4'h9, 0, 1, 1, 0, 0, 1, 8'd5));
        add("reset_mid_settle", 1, 8'h7D, 4'h6, 1, rst_vals);
        add("post_rst_window",  0, 8'h7D, 4'h6, 3, rst_vals);
        add("post_rst_accept6", 0, 8'h7D, 4'h6, 1, mk(4'h6, 1, 0, 0, 0, 0, 0, 8'd1));
        add("settle1_pre_rst",  0, 8'h06, 4'h1, 3, mk(4'h6, 1, 0, 0, 0, 0, 0, 8'd1));
        add("reset_on_accept",  1, 8'h06, 4'h1, 1, rst_vals);
        add("accept1_after_rst",0, 8'h06, 4'h1, 4, mk(4'h1, 1, 0, 0, 0, 0, 0, 8'd1));

        foreach (vecs[i]) begin
            reset   = vecs[i].rst;
            seg_in  = vecs[i].seg;
            led_nib = vecs[i].nib;
            tick(vecs[i].edges);
            act = {value_a, vv_a, dp_a, blank_a, inv_a, mm_a, mme_a, count_a};
            check(vecs[i].name, act, vecs[i].exp);
        end

        // Counter saturation with a 2-bit count
        pat_b[0] = 8'h06; pat_b[1] = 8'h5B; pat_b[2] = 8'h4F; pat_b[3] = 8'h66; pat_b[4] = 8'h6D;
        exp_b[0] = 2'd1;  exp_b[1] = 2'd2;  exp_b[2] = 2'd3;  exp_b[3] = 2'd3;  exp_b[4] = 2'd3;
        reset = 1'b1; seg_in = 8'h00; tick(1);
        reset = 1'b0;
        for (int d = 0; d < 5; d++) begin
            seg_in  = pat_b[d];
            led_nib = 4'(d + 1);
            tick(4);
            check_cnt($sformatf("sat_count_%0d", d + 1), {6'd0, count_b}, {6'd0, exp_b[d]});
            check_cnt($sformatf("sat_value_%0d", d + 1), {4'd0, value_b}, 8'(d + 1));
        end

        // Single-cycle window: every change accepted on its first edge
        reset = 1'b1; seg_in = 8'h00; led_nib = 4'h2; tick(1);
        reset = 1'b0;
        seg_in = 8'h5B; tick(1);
        act = {value_c, vv_c, dp_c, blank_c, inv_c, mm_c, mme_c, count_c};
        check("s1_accept2", act, mk(4'h2, 1, 0, 0, 0, 0, 0, 8'd1));
        seg_in = 8'h4F; tick(1);
        act = {value_c, vv_c, dp_c, blank_c, inv_c, mm_c, mme_c, count_c};
        check("s1_accept3_mismatch", act, mk(4'h3, 1, 0, 0, 0, 1, 1, 8'd2));
        seg_in = 8'h00; tick(1);
        act = {value_c, vv_c, dp_c, blank_c, inv_c, mm_c, mme_c, count_c};
        check("s1_blank", act, mk(4'h3, 0, 0, 1, 0, 0, 1, 8'd2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_decoder_monitor.md
Name: seg7_decoder_monitor

Overview:
- Receive end of the 7-segment display bus: samples an 8-bit segment pattern (bit0=a … bit6=g, bit7=dp) and recovers the hex digit it shows.
- Debounces the pattern, classifies it as a valid digit, blank or illegal, and checks it against a 4-bit LED nibble that claims the same value.
- Counts accepted digit changes.
- Sits beside the display driver in the lab top as a self-check and readback path; outputs are routed to LEDs or LCD debug fields.

Parameters:
- STABLE_CYCLES, 4, consecutive rising edges a pattern must hold before it is accepted. Legal range 1..255.
- NBITS_CNT, 8, width of the accepted-change counter.

Ports:
- clk_2  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- seg_in  input  8  segment pattern under observation.
- led_nib  input  4  value the display driver claims to show; sampled when a digit is accepted.
- value  output  4  last accepted decoded digit, 0x0..0xF.
- value_valid  output  1  accepted pattern is a legal digit.
- dp  output  1  decimal-point bit of the accepted pattern.
- blank  output  1  accepted pattern has bits 6:0 = 0.
- invalid  output  1  accepted pattern is nonblank and not in the digit table.
- mismatch  output  1  at the last accept, value != led_nib (legal digits only).
- mismatch_err  output  1  sticky OR of every mismatch since reset.
- count  output  NBITS_CNT  number of accepted value changes, saturating.

Behaviour:
- Decode table on bits 6:0:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - 00 is blank; any other pattern is invalid.
- Reset, applied at the edge where reset=1:
  - value=0, value_valid=0, dp=0, blank=1, invalid=0, mismatch=0, mismatch_err=0, count=0.
  - Stability counter cleared; sampled-pattern register cleared to 0x00.
  - The FSM goes to BLANK.
- FSM states are BLANK, SETTLE, LOCKED and ILLEGAL.
  - Any edge where seg_in differs from the previously sampled pattern: go to SETTLE and restart the stability count at 1.
  - SETTLE with an unchanged pattern: increment the count. When it reaches STABLE_CYCLES, accept on that same edge and go to:
    - LOCKED for a legal digit;
    - BLANK for a blank pattern;
    - ILLEGAL for an invalid pattern.
  - LOCKED, BLANK and ILLEGAL with an unchanged pattern: hold. Outputs are stable and no re-accept occurs.
- Acceptance latency: a new pattern first present at edge k is accepted at edge k+STABLE_CYCLES-1. Its outputs are visible after that edge.
  - STABLE_CYCLES=1 means every change is accepted on its first edge.
- During SETTLE all outputs hold their previous accepted values.
- On accept of a legal digit:
  - value=decode, value_valid=1, blank=0, invalid=0, dp=seg_in[7].
  - mismatch=(decode != led_nib); mismatch_err |= mismatch.
  - count increments if decode differs from the previously accepted legal value, or if no legal value has been accepted since the last reset/blank/illegal state.
- On accept of a blank pattern: value holds, value_valid=0, blank=1, invalid=0, mismatch=0, dp=seg_in[7].
- On accept of an invalid pattern: value holds, value_valid=0, blank=0, invalid=1, mismatch=0, dp=seg_in[7].
- dp does not affect classification, but a dp-only change still counts as a pattern change and restarts settling.
- count saturates at 2^NBITS_CNT-1 and never wraps.
- mismatch_err clears only on reset.
- reset=1 has priority over every other event, including an accept on the same edge.
  - Reset mid-settle discards the partial count.
  - After reset is released, a full STABLE_CYCLES window is required before the next accept.
- All outputs are registered; there is no combinational path from an input to an output.

Test Plan:
1. Reset, then seg_in=0x6D with led_nib=5 held for 4 edges -> after the 4th edge value=5, value_valid=1, blank=0, mismatch=0, count=1. Before that edge, outputs are unchanged.
2. seg_in=0x7D for 2 edges, then 0x6F held, led_nib=9 -> no accept of 6. Accept of value=9 occurs 4 edges after 0x6F first appears; count increments by exactly 1.
3. seg_in=0x39 with led_nib=9 -> value=C, mismatch=1, mismatch_err=1. Then seg_in=0x6F with led_nib=9 -> mismatch=0, mismatch_err remains 1 until reset.
4. seg_in=0x00 held -> blank=1, value_valid=0, value holds 9. Then seg_in=0x49 held -> invalid=1, blank=0. Then 0x6F -> count increments because the legal-value history was broken.
5. NBITS_CNT=2: accept 1, 2, 3, 4, 5 in sequence -> count reads 1, 2, 3, 3, 3 (saturates at 3).
6. seg_in=0x7D held for 2 edges, reset=1 for one edge, seg_in still 0x7D -> all outputs equal reset values. The accept of 6 occurs only after STABLE_CYCLES further edges.
